mux_sel_arbiter: RTL and testbench
==================================

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8, maximum consecutive grant cycles while the other channel is requesting.
REQ-002 Parameter DEAD_CYCLES, default 2, number of break-before-make cycles (range 1..15).
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 req0  input  1  channel 0 (mux in0) requests the output; level-sensitive.
REQ-006 req1  input  1  channel 1 (mux in1) requests the output; level-sensitive.
REQ-007 s  output  1  registered select, driving the downstream 2:1 mux select.
REQ-008 gnt0  output  1  channel 0 owns the mux output.
REQ-009 gnt1  output  1  channel 1 owns the mux output.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 The block SHALL implement the states IDLE, GRANT0, GRANT1 and DEAD, with all outputs registered.
REQ-012 The block SHALL never assert gnt0 and gnt1 in the same cycle.
REQ-013 In GRANTx, gntx SHALL be 1 and s SHALL equal x.
REQ-014 s SHALL change value only on the edge that enters GRANT0 or GRANT1, and SHALL otherwise hold its value, including in IDLE and DEAD.
REQ-015 Arbitration SHALL be round-robin using a last-granted flag:
- a sole requester wins;
- if both channels request, the channel other than the last-granted one wins.
REQ-016 From IDLE, a request sampled at edge n SHALL produce gnt at edge n+1, giving a one-cycle latency.
REQ-017 A hold counter SHALL clear on entry to GRANTx and increment each cycle spent in GRANTx.
REQ-018 GRANTx SHALL be left when reqx is sampled low, or when the counter reaches HOLD_MAX-1 while the other channel is requesting.
REQ-019 If the counter reaches HOLD_MAX-1 while the other channel is not requesting, the grant SHALL persist and the counter SHALL wrap to 0.
REQ-020 In DEAD, gnt0 and gnt1 SHALL be 0 and a dead counter SHALL count DEAD_CYCLES cycles.
REQ-021 On the last DEAD cycle, the block SHALL re-arbitrate per REQ-015 and enter GRANT0, GRANT1 or IDLE.
REQ-022 Requests that change during DEAD SHALL be ignored until the re-arbitration cycle.
REQ-023 If reqx drops and rises again within DEAD and the other channel is idle, channel x SHALL be re-granted after DEAD.

Reset
REQ-024 While reset_n is sampled low, the block SHALL enter IDLE with s=0, gnt0=0, gnt1=0, busy=0, both counters at 0 and last-granted=1, so that channel 0 wins the first tie.
REQ-025 Reset asserted mid-grant or mid-DEAD SHALL take effect at the next edge with no dead time.
REQ-026 Release of reset SHALL not itself produce a grant; arbitration SHALL begin on the first edge with reset_n high.

Configuration
REQ-027 Macro MUX_SEL_DEADTIME_EN SHALL control DEAD insertion.
- Defined: every exit from GRANTx SHALL pass through DEAD.
- Undefined: DEAD SHALL not exist, and a GRANTx exit SHALL re-arbitrate in the same cycle, going directly to GRANTother (gntx falls and gntother rises on the same edge) or to IDLE.

Verification
REQ-028 Bench SHALL check: reset_n=0 for 3 cycles with req0=req1=1 -> s=0, gnt0=gnt1=0, busy=0 throughout; after release, gnt0=1 one edge later.
REQ-029 Bench SHALL check: req1 raised alone in IDLE at edge 10 -> gnt1=1, s=1 from edge 11; req1 dropped at edge 20 -> with MUX_SEL_DEADTIME_EN, gnt1=0 from edge 21, IDLE at edge 23, s stays 1.
REQ-030 Bench SHALL check: req0 and req1 held high continuously with HOLD_MAX=8 and DEAD_CYCLES=2 -> gnt0 for 8 cycles, 2 dead cycles, gnt1 for 8 cycles, repeating; gnt0 and gnt1 never both 1.
REQ-031 Bench SHALL check: req0 held high alone for 20 cycles -> gnt0 stays 1 across the counter wrap with no DEAD entry.
REQ-032 Bench SHALL check: without the macro, req0 drops while req1 is high -> on a single edge gnt0 goes 1->0, gnt1 goes 0->1 and s goes 0->1.
REQ-033 Bench SHALL check: reset_n pulsed low for 1 cycle during GRANT1 -> IDLE with s=0 on the next edge, and the next tie is granted to channel 0.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter
//
// Round-robin arbiter that owns the select line of a downstream 2:1 mux.
// Each channel raises a level-sensitive request. The winner keeps the mux
// until it drops its request. If the other channel is waiting, the winner
// is also forced off after HOLD_MAX consecutive cycles. All outputs are
// registered.
//
// Optional feature (macro MUX_SEL_DEADTIME_EN):
//   Defined   - every exit from a grant passes through DEAD_CYCLES cycles
//               of break-before-make, with both grants low.
//   Undefined - no DEAD state. A grant exit re-arbitrates immediately.
//
// Parameters:
//   HOLD_MAX    - max consecutive grant cycles while the other side waits
//   DEAD_CYCLES - break-before-make length, 1..15
//
// Ports:
//   clock   in   single clock, rising edge
//   reset_n in   synchronous active-low reset
//   req0    in   channel 0 (mux in0) request
//   req1    in   channel 1 (mux in1) request
//   s       out  registered mux select
//   gnt0    out  channel 0 owns the mux output
//   gnt1    out  channel 1 owns the mux output
//   busy    out  high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module mux_sel_arbiter #(
   parameter int HOLD_MAX    = 8,
   parameter int DEAD_CYCLES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic req0,
   input  logic req1,
   output logic s,
   output logic gnt0,
   output logic gnt1,
   output logic busy
);

`ifdef MUX_SEL_DEADTIME_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      DEAD   = 2'd3
   } arbState_t;
`else
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arbState_t;
`endif

   localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

   // Reject parameter values that would make the counters meaningless.
   if (HOLD_MAX < 1 || DEAD_CYCLES < 1 || DEAD_CYCLES > 15) begin : g_badParams
      $error("mux_sel_arbiter: HOLD_MAX must be >= 1 and DEAD_CYCLES in 1..15");
   end

   arbState_t         r_state;
   arbState_t         w_nextState;
   arbState_t         w_winner;
   logic [HOLD_W-1:0] r_holdCnt;
   logic [HOLD_W-1:0] w_nextHold;
   logic              r_lastGnt;
   logic              w_mine;
   logic              w_other;
   logic              w_exit;
   logic              r_s;
   logic              r_gnt0;
   logic              r_gnt1;
   logic              r_busy;

`ifdef MUX_SEL_DEADTIME_EN
   localparam logic [3:0] DEAD_LAST = 4'(DEAD_CYCLES - 1);
   logic [3:0] r_deadCnt;
   logic [3:0] w_nextDead;
`endif

   // Round-robin pick from the requests as they are right now. A sole
   // requester always wins. On a tie, the channel that did not win last
   // time wins, so r_lastGnt resets to 1 to hand channel 0 the first tie.
   always_comb begin
      w_winner = IDLE;
      if (req0 && req1) begin
         w_winner = r_lastGnt ? GRANT0 : GRANT1;
      end else if (req0) begin
         w_winner = GRANT0;
      end else if (req1) begin
         w_winner = GRANT1;
      end
   end

   // Work out whether the current owner has to let go. It releases when
   // it drops its own request, or when its hold window runs out while the
   // other channel is waiting. If nobody is waiting, the window just
   // wraps and the owner keeps the mux.
   always_comb begin
      w_mine  = (r_state == GRANT1) ? req1 : req0;
      w_other = (r_state == GRANT1) ? req0 : req1;
      w_exit  = !w_mine || ((r_holdCnt == HOLD_LAST) && w_other);
   end

   // Next-state logic. The hold counter defaults to zero, so it is
   // already cleared on the edge that enters any grant. It only advances
   // while a grant is held. The winner is used directly on a grant exit
   // because the exiting channel can never win the pick at that moment:
   // either it has dropped its request, or it holds last-granted and
   // loses the tie.
   always_comb begin
      w_nextState = r_state;
      w_nextHold  = '0;
`ifdef MUX_SEL_DEADTIME_EN
      w_nextDead  = '0;
`endif
      case (r_state)
         IDLE: begin
            w_nextState = w_winner;
         end
         GRANT0, GRANT1: begin
            if (w_exit) begin
`ifdef MUX_SEL_DEADTIME_EN
               w_nextState = DEAD;
`else
               w_nextState = w_winner;
`endif
            end else if (r_holdCnt != HOLD_LAST) begin
               w_nextHold = r_holdCnt + 1'b1;
            end
         end
`ifdef MUX_SEL_DEADTIME_EN
         DEAD: begin
            if (r_deadCnt == DEAD_LAST) begin
               w_nextState = w_winner;
            end else begin
               w_nextDead = r_deadCnt + 1'b1;
            end
         end
`endif
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State and counter registers. Reset is synchronous and wins over
   // everything, so a reset in the middle of a grant or a dead period
   // drops straight to IDLE without any dead time.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_holdCnt <= '0;
         r_lastGnt <= 1'b1;
`ifdef MUX_SEL_DEADTIME_EN
         r_deadCnt <= '0;
`endif
      end else begin
         r_state   <= w_nextState;
         r_holdCnt <= w_nextHold;
`ifdef MUX_SEL_DEADTIME_EN
         r_deadCnt <= w_nextDead;
`endif
         if (w_nextState == GRANT0) begin
            r_lastGnt <= 1'b0;
         end else if (w_nextState == GRANT1) begin
            r_lastGnt <= 1'b1;
         end
      end
   end

   // Output registers are loaded from the next state, so they line up
   // exactly with r_state. The select only moves on an edge that lands
   // in a grant, and it holds its last value through IDLE and DEAD.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_s    <= 1'b0;
         r_gnt0 <= 1'b0;
         r_gnt1 <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_gnt0 <= (w_nextState == GRANT0);
         r_gnt1 <= (w_nextState == GRANT1);
         r_busy <= (w_nextState != IDLE);
         if (w_nextState == GRANT0) begin
            r_s <= 1'b0;
         end else if (w_nextState == GRANT1) begin
            r_s <= 1'b1;
         end
      end
   end

   assign s    = r_s;
   assign gnt0 = r_gnt0;
   assign gnt1 = r_gnt1;
   assign busy = r_busy;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_arbiter
//
// Self-checking bench for mux_sel_arbiter with HOLD_MAX=8 and
// DEAD_CYCLES=2. It follows MUX_SEL_DEADTIME_EN, so it works with or
// without the dead-time feature. A cycle-level reference model tracks the
// owner, how many cycles the owner has held the mux, the remaining dead
// cycles and the last winner. Directed scenarios add fixed expectations
// on top of that model.
// ---------------------------------------------------------------------------
module tb_mux_sel_arbiter;

   localparam int HOLD_MAX    = 8;
   localparam int DEAD_CYCLES = 2;
`ifdef MUX_SEL_DEADTIME_EN
   localparam int DEAD_LEN = DEAD_CYCLES;
`else
   localparam int DEAD_LEN = 0;
`endif

   logic clock = 1'b0;
   logic reset_n;
   logic req0;
   logic req1;
   logic s;
   logic gnt0;
   logic gnt1;
   logic busy;

   int testCount = 0;
   int failCount = 0;

   int   mOwner    = -1;
   int   mCycles   = 0;
   int   mDeadLeft = 0;
   int   mLast     = 1;
   logic mS        = 1'b0;

   mux_sel_arbiter #(
      .HOLD_MAX    (HOLD_MAX),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .req0    (req0),
      .req1    (req1),
      .s       (s),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .busy    (busy)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Hard stop in case something stalls the stimulus sequence.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1, "[TB] watchdog expired");
   end

   // Round-robin pick: a sole requester wins, and a tie goes to the
   // channel that did not win last time. -1 means nobody.
   function automatic int pickWinner(input logic r0, input logic r1, input int last);
      if (r0 && r1) return 1 - last;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   // Hand the mux to the given channel (-1 means nobody).
   task automatic grantTo(input int w);
      mOwner = w;
      if (w >= 0) begin
         mCycles = 1;
         mLast   = w;
         mS      = (w == 1);
      end
   endtask

   // One clock edge of the reference model, using the inputs sampled on
   // that edge. The owner gives up the mux when its request is gone, or
   // when it has held the mux a whole multiple of HOLD_MAX cycles while
   // the other channel is waiting.
   task automatic modelEdge(input logic r0, input logic r1, input logic rn);
      logic mine;
      logic theirs;
      if (!rn) begin
         mOwner    = -1;
         mCycles   = 0;
         mDeadLeft = 0;
         mLast     = 1;
         mS        = 1'b0;
      end else if (mDeadLeft > 0) begin
         if (mDeadLeft == 1) begin
            mDeadLeft = 0;
            grantTo(pickWinner(r0, r1, mLast));
         end else begin
            mDeadLeft--;
         end
      end else if (mOwner < 0) begin
         grantTo(pickWinner(r0, r1, mLast));
      end else begin
         mine   = (mOwner == 1) ? r1 : r0;
         theirs = (mOwner == 1) ? r0 : r1;
         if (!mine || (((mCycles % HOLD_MAX) == 0) && theirs)) begin
            if (DEAD_LEN > 0) begin
               mOwner    = -1;
               mDeadLeft = DEAD_LEN;
            end else begin
               grantTo(pickWinner(r0, r1, mLast));
            end
         end else begin
            mCycles++;
         end
      end
   endtask

   // Drive the inputs, take one rising edge, update the model, then
   // settle 1 time unit past the edge before anyone samples outputs.
   task automatic applyStimulus(input logic r0, input logic r1, input logic rn);
      reset_n = rn;
      req0    = r0;
      req1    = r1;
      @(posedge clock);
      modelEdge(r0, r1, rn);
      #1;
   endtask

   // Hold reset for 3 cycles with both requests high. Everything must
   // stay low. The first edge after release grants channel 0.
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         testCount++;
         if ({s, gnt0, gnt1, busy} !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_hold[%0d]: s,gnt0,gnt1,busy=%b required 0000", i, {s, gnt0, gnt1, busy});
         end
      end
      applyStimulus(1'b1, 1'b1, 1'b1);
      testCount++;
      if ({s, gnt0, gnt1, busy} !== 4'b0101) begin
         failCount++;
         $display("[TB] FAIL reset_release: s,gnt0,gnt1,busy=%b required 0101", {s, gnt0, gnt1, busy});
      end
   endtask

   // Channel 1 alone. req1 rises after edge 10, is granted from edge 11,
   // drops after edge 20, and the grant ends at edge 21. With dead time,
   // busy stays high until IDLE at edge 23. The select stays at 1.
   task automatic test_single_request();
      logic expBusy;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int e = 11; e <= 20; e++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         testCount++;
         if ({s, gnt0, gnt1, busy} !== 4'b1011) begin
            failCount++;
            $display("[TB] FAIL single_grant edge %0d: s,gnt0,gnt1,busy=%b required 1011", e, {s, gnt0, gnt1, busy});
         end
      end
      for (int e = 21; e <= 23; e++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         expBusy = ((e - 21) < DEAD_LEN);
         testCount++;
         if ({s, gnt0, gnt1, busy} !== {3'b100, expBusy}) begin
            failCount++;
            $display("[TB] FAIL single_release edge %0d: s,gnt0,gnt1,busy=%b required %b", e, {s, gnt0, gnt1, busy}, {3'b100, expBusy});
         end
      end
   endtask

   // Both channels request continuously. The grant alternates: HOLD_MAX
   // cycles of channel 0, the dead gap, HOLD_MAX cycles of channel 1,
   // the dead gap, and round again.
   task automatic test_back_to_back();
      int period;
      int phase;
      logic [1:0] expGnt;
      period = 2 * (HOLD_MAX + DEAD_LEN);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3 * period; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b1);
         phase = k % period;
         if (phase < HOLD_MAX) expGnt = 2'b01;
         else if (phase < HOLD_MAX + DEAD_LEN) expGnt = 2'b00;
         else if (phase < 2 * HOLD_MAX + DEAD_LEN) expGnt = 2'b10;
         else expGnt = 2'b00;
         testCount++;
         if ({gnt1, gnt0} !== expGnt) begin
            failCount++;
            $display("[TB] FAIL back_to_back cycle %0d: gnt1,gnt0=%b required %b", k, {gnt1, gnt0}, expGnt);
         end
         testCount++;
         if ({s, gnt0, gnt1, busy} !== {mS, mOwner == 0, mOwner == 1, (mOwner >= 0) || (mDeadLeft > 0)}) begin
            failCount++;
            $display("[TB] FAIL back_to_back_model cycle %0d: s,gnt0,gnt1,busy=%b required %b", k, {s, gnt0, gnt1, busy},
                     {mS, mOwner == 0, mOwner == 1, (mOwner >= 0) || (mDeadLeft > 0)});
         end
      end
   endtask

   // Channel 0 alone for 20 cycles. The hold window wraps, but the grant
   // never drops and the block never goes dead.
   task automatic test_hold_wrap();
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         testCount++;
         if ({s, gnt0, gnt1, busy} !== 4'b0101) begin
            failCount++;
            $display("[TB] FAIL hold_wrap cycle %0d: s,gnt0,gnt1,busy=%b required 0101", k, {s, gnt0, gnt1, busy});
         end
      end
   endtask

   // Channel 0 owns the mux, channel 1 is waiting, then channel 0 drops.
   // Without dead time the handover is one edge. With it, both grants
   // stay low for the dead gap first.
   task automatic test_handover();
      logic [3:0] expOut;
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) applyStimulus(1'b1, 1'b1, 1'b1);
      testCount++;
      if ({s, gnt0, gnt1, busy} !== 4'b0101) begin
         failCount++;
         $display("[TB] FAIL handover_before: s,gnt0,gnt1,busy=%b required 0101", {s, gnt0, gnt1, busy});
      end
      for (int k = 0; k <= DEAD_LEN; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         expOut = (k < DEAD_LEN) ? 4'b0001 : 4'b1011;
         testCount++;
         if ({s, gnt0, gnt1, busy} !== expOut) begin
            failCount++;
            $display("[TB] FAIL handover_after[%0d]: s,gnt0,gnt1,busy=%b required %b", k, {s, gnt0, gnt1, busy}, expOut);
         end
      end
   endtask

   // A one-cycle reset pulse while channel 1 holds the mux. The block
   // goes straight to IDLE with s=0. The next tie goes to channel 0.
   task automatic test_reset_mid_grant();
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b1);
      testCount++;
      if ({s, gnt0, gnt1, busy} !== 4'b1011) begin
         failCount++;
         $display("[TB] FAIL mid_grant_setup: s,gnt0,gnt1,busy=%b required 1011", {s, gnt0, gnt1, busy});
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      testCount++;
      if ({s, gnt0, gnt1, busy} !== 4'b0000) begin
         failCount++;
         $display("[TB] FAIL mid_grant_reset: s,gnt0,gnt1,busy=%b required 0000", {s, gnt0, gnt1, busy});
      end
      applyStimulus(1'b1, 1'b1, 1'b1);
      testCount++;
      if ({s, gnt0, gnt1, busy} !== 4'b0101) begin
         failCount++;
         $display("[TB] FAIL mid_grant_tie: s,gnt0,gnt1,busy=%b required 0101", {s, gnt0, gnt1, busy});
      end
   endtask

   // Random request traffic with occasional resets. Each request toggles
   // rarely, so long holds and timeouts happen naturally. Every cycle is
   // compared against the model and checked for mutual exclusion.
   task automatic test_random();
      logic r0 = 1'b0;
      logic r1 = 1'b0;
      logic rn;
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) r0 = ~r0;
         if ($urandom_range(0, 5) == 0) r1 = ~r1;
         rn = ($urandom_range(0, 59) != 0);
         applyStimulus(r0, r1, rn);
         testCount++;
         if ({s, gnt0, gnt1, busy} !== {mS, mOwner == 0, mOwner == 1, (mOwner >= 0) || (mDeadLeft > 0)}) begin
            failCount++;
            $display("[TB] FAIL random_model cycle %0d: s,gnt0,gnt1,busy=%b required %b", i, {s, gnt0, gnt1, busy},
                     {mS, mOwner == 0, mOwner == 1, (mOwner >= 0) || (mDeadLeft > 0)});
         end
         testCount++;
         if ((gnt0 & gnt1) !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL random_exclusive cycle %0d: gnt0&gnt1=%b required 0", i, gnt0 & gnt1);
         end
      end
   endtask

   // Run the scenarios in order, then print the summary.
   initial begin
      reset_n = 1'b0;
      req0    = 1'b0;
      req1    = 1'b0;
      test_reset();
      test_single_request();
      test_back_to_back();
      test_hold_wrap();
      test_handover();
      test_reset_mid_grant();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
